// File: rtl/katp91_ram_pkg.sv
// Shared definitions for the two-requester RAM arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default RAM word-address and word widths
//   REQ_CPU / REQ_DMA       : requester indices into req/gnt/done
//   state_t                 : arbiter FSM states
package katp91_ram_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 16;

    localparam int REQ_CPU = 0;
    localparam int REQ_DMA = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational 2-way picker for the RAM arbiter.
//   req  [1:0] : pending requests (bit 0 = CPU, bit 1 = DMA)
//   last       : requester served most recently (0 = CPU, 1 = DMA)
//   win  [1:0] : one-hot winner, all zero when req == 0
// Build option: RAM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking
// (priority to the requester not served last); otherwise the CPU always
// wins ties.
module ram_arb_pick
    import katp91_ram_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
    always_comb begin
        win = 2'b00;
        if (req[REQ_CPU] && req[REQ_DMA]) begin
            // Tie: the one that did not go last goes now.
            if (last) begin
                win[REQ_CPU] = 1'b1;
            end else begin
                win[REQ_DMA] = 1'b1;
            end
        end else if (req[REQ_CPU]) begin
            win[REQ_CPU] = 1'b1;
        end else if (req[REQ_DMA]) begin
            win[REQ_DMA] = 1'b1;
        end
    end
`else
    // Fixed priority does not need the history pointer.
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        win = 2'b00;
        if (req[REQ_CPU]) begin
            win[REQ_CPU] = 1'b1;
        end else if (req[REQ_DMA]) begin
            win[REQ_DMA] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM.
// Each access takes IDLE/RESP (grant) -> CMD (RAM strobe) -> RESP (done),
// so gnt-to-done latency is 2 cycles and back-to-back throughput is one
// access per 2 cycles (a new grant may be issued in the RESP cycle).
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   req[1:0]                : requests (bit 0 = CPU, bit 1 = loader/DMA)
//   addr0/1, we0/1, wdata0/1: per-requester access, sampled only on gnt
//   gnt[1:0]                : one-cycle pulse, request accepted and latched
//   done[1:0]               : one-cycle pulse, access complete
//   rdata                   : shared read data, holds last read value
//   ram_addr/enable/write/read/wdata : RAM side command
//   ram_rdata               : RAM registered read data (one cycle after CMD)
// Build option: RAM_ARB_ROUND_ROBIN_EN (see ram_arb_pick).
module ram_arbiter
    import katp91_ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              we0,
    input  logic              we1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_enable,
    output logic              ram_write,
    output logic              ram_read,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t            state_reg;
    state_t            state_next;
    logic              owner_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              last_reg;

    logic [1:0]        win;
    logic              win_idx;
    logic              resp_active;

    logic [ADDR_W-1:0] addr_in  [2];
    logic              we_in    [2];
    logic [DATA_W-1:0] wdata_in [2];

    assign addr_in[REQ_CPU]  = addr0;
    assign addr_in[REQ_DMA]  = addr1;
    assign we_in[REQ_CPU]    = we0;
    assign we_in[REQ_DMA]    = we1;
    assign wdata_in[REQ_CPU] = wdata0;
    assign wdata_in[REQ_DMA] = wdata1;

    ram_arb_pick u_pick (
        .req  (req),
        .last (last_reg),
        .win  (win)
    );

    assign win_idx = win[REQ_DMA];

    always_comb begin
        state_next  = state_reg;
        gnt         = 2'b00;
        resp_active = 1'b0;
        ram_enable  = 1'b0;
        ram_write   = 1'b0;
        ram_read    = 1'b0;
        ram_addr    = '0;
        ram_wdata   = '0;

        case (state_reg)
            CMD: begin
                ram_enable = 1'b1;
                ram_write  = we_reg;
                ram_addr   = addr_reg;
                ram_wdata  = wdata_reg;
                state_next = RESP;
            end
            default: begin
                // IDLE and RESP are both arbitration points; an unused
                // encoding behaves as IDLE.
                resp_active = (state_reg == RESP);
                ram_read    = resp_active && !we_reg;
                if (|req) begin
                    gnt        = win;
                    state_next = CMD;
                end else begin
                    state_next = IDLE;
                end
            end
        endcase

        // Reset kills the cycle outright: no grant that would be lost,
        // no done for an aborted access, nothing on the RAM bus.
        if (!rst_n) begin
            state_next  = IDLE;
            gnt         = 2'b00;
            resp_active = 1'b0;
            ram_enable  = 1'b0;
            ram_write   = 1'b0;
            ram_read    = 1'b0;
            ram_addr    = '0;
            ram_wdata   = '0;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_done
            assign done[gi] = resp_active && (owner_reg == (gi == REQ_DMA));
        end
    endgenerate

    // Read data passes straight through in a read RESP and is held after.
    assign rdata = ram_read ? ram_rdata : rdata_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            owner_reg <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            // Pretend DMA went last so the first tie goes to the CPU.
            last_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            if (|gnt) begin
                owner_reg <= win_idx;
                we_reg    <= we_in[win_idx];
                addr_reg  <= addr_in[win_idx];
                wdata_reg <= wdata_in[win_idx];
                last_reg  <= win_idx;
            end
            if (ram_read) begin
                rdata_reg <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural synchronous RAM.
// Expected tie-break sequence follows RAM_ARB_ROUND_ROBIN_EN.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [10:0] addr0, addr1;
    logic        we0, we1;
    logic [15:0] wdata0, wdata1;
    logic [1:0]  gnt, done;
    logic [15:0] rdata;
    logic [10:0] ram_addr;
    logic        ram_enable, ram_write, ram_read;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;

    logic [15:0] mem [0:2047];

    int checks   = 0;
    int failures = 0;
    logic gnt_prev = 1'b0;
    logic [1:0] exp_seq [4];

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .addr0      (addr0),
        .addr1      (addr1),
        .we0        (we0),
        .we1        (we1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .gnt        (gnt),
        .done       (done),
        .rdata      (rdata),
        .ram_addr   (ram_addr),
        .ram_enable (ram_enable),
        .ram_write  (ram_write),
        .ram_read   (ram_read),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // RAM: captures on the edge, registered read data one cycle later.
    always @(posedge clk) begin
        if (ram_enable) begin
            if (ram_write) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ram_enable may only be high in CMD, i.e. the cycle right after a grant.
    always @(negedge clk) begin
        if (ram_enable) check_eq("en_only_in_cmd", {31'd0, gnt_prev}, 32'd1);
        if (ram_write && !ram_enable) check_eq("write_without_enable", 32'd1, 32'd0);
        gnt_prev = |gnt;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete access from an idle arbiter by a single requester.
    task automatic do_access(input int who, input logic we, input logic [10:0] a,
                             input logic [15:0] d, input logic [15:0] exp_rd);
        logic [1:0] oh;
        oh = (who == 1) ? 2'b10 : 2'b01;
        if (who == 1) begin
            addr1 = a; we1 = we; wdata1 = d;
        end else begin
            addr0 = a; we0 = we; wdata0 = d;
        end
        req = oh;
        #1;
        check_eq("acc_gnt", {30'd0, gnt}, {30'd0, oh});
        step();
        req = 2'b00;
        #1;
        check_eq("acc_cmd_en", {31'd0, ram_enable}, 32'd1);
        check_eq("acc_cmd_wr", {31'd0, ram_write}, {31'd0, we});
        check_eq("acc_cmd_addr", {21'd0, ram_addr}, {21'd0, a});
        check_eq("acc_cmd_done", {30'd0, done}, 32'd0);
        if (we) check_eq("acc_cmd_wdata", {16'd0, ram_wdata}, {16'd0, d});
        step();
        check_eq("acc_resp_done", {30'd0, done}, {30'd0, oh});
        check_eq("acc_resp_rd", {31'd0, ram_read}, {31'd0, !we});
        check_eq("acc_resp_en", {31'd0, ram_enable}, 32'd0);
        if (!we) check_eq("acc_rdata", {16'd0, rdata}, {16'd0, exp_rd});
        step();
        check_eq("acc_idle_done", {30'd0, done}, 32'd0);
        if (!we) check_eq("acc_rdata_hold", {16'd0, rdata}, {16'd0, exp_rd});
        $display("txn who=%0d we=%0d addr=%03h data=%04h", who, we, a, we ? d : rdata);
    endtask

    initial begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
`else
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b01; exp_seq[2] = 2'b01; exp_seq[3] = 2'b01;
`endif
        rst_n = 1'b0; req = 2'b11;
        addr0 = '0; addr1 = '0; we0 = 1'b0; we1 = 1'b0; wdata0 = '0; wdata1 = '0;
        step();
        step();
        check_eq("rst_gnt", {30'd0, gnt}, 32'd0);
        check_eq("rst_done", {30'd0, done}, 32'd0);
        check_eq("rst_en", {31'd0, ram_enable}, 32'd0);
        check_eq("rst_rdata", {16'd0, rdata}, 32'd0);
        req = 2'b00; rst_n = 1'b1;
        step();

        // Scenario 1 and 2: CPU write then read back.
        do_access(0, 1'b1, 11'h005, 16'hBEEF, 16'h0000);
        do_access(0, 1'b0, 11'h005, 16'h0000, 16'hBEEF);

        // Scenario 3: both requesting continuously from a fresh reset.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        addr0 = 11'h005; we0 = 1'b0; addr1 = 11'h005; we1 = 1'b0;
        req = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            check_eq("tie_gnt", {30'd0, gnt}, {30'd0, exp_seq[k]});
            if (k > 0) check_eq("tie_done", {30'd0, done}, {30'd0, exp_seq[k-1]});
            $display("txn tie k=%0d gnt=%b", k, gnt);
            step();
            check_eq("tie_cmd_gnt", {30'd0, gnt}, 32'd0);
            if (k == 3) req = 2'b00;
            step();
        end
        check_eq("tie_last_done", {30'd0, done}, {30'd0, exp_seq[3]});
        check_eq("tie_last_gnt", {30'd0, gnt}, 32'd0);
        step();

        // Scenario 4: DMA write alone, CPU read arrives during its RESP.
        req = 2'b10; we1 = 1'b1; addr1 = 11'h010; wdata1 = 16'h1234;
        #1;
        check_eq("s4_gnt_dma", {30'd0, gnt}, 32'd2);
        step();
        req = 2'b00;
        step();
        req = 2'b01; we0 = 1'b0; addr0 = 11'h010;
        #1;
        check_eq("s4_done_dma", {30'd0, done}, 32'd2);
        check_eq("s4_gnt_cpu_in_resp", {30'd0, gnt}, 32'd1);
        step();
        req = 2'b00;
        #1;
        check_eq("s4_cmd_addr", {21'd0, ram_addr}, 32'h010);
        check_eq("s4_cmd_en", {31'd0, ram_enable}, 32'd1);
        step();
        check_eq("s4_done_cpu", {30'd0, done}, 32'd1);
        check_eq("s4_rdata", {16'd0, rdata}, 32'h1234);
        $display("txn s4 dma-then-cpu rdata=%04h", rdata);
        step();

        // Scenario 5: reset during CMD of a read aborts it.
        req = 2'b01; we0 = 1'b0; addr0 = 11'h005;
        #1;
        check_eq("s5_gnt", {30'd0, gnt}, 32'd1);
        step();
        rst_n = 1'b0; req = 2'b00;
        #1;
        check_eq("s5_rst_en", {31'd0, ram_enable}, 32'd0);
        check_eq("s5_rst_done", {30'd0, done}, 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        check_eq("s5_done", {30'd0, done}, 32'd0);
        check_eq("s5_gnt", {30'd0, gnt}, 32'd0);
        check_eq("s5_ram", {17'd0, ram_enable, ram_write, ram_read, ram_addr}, 32'd0);
        check_eq("s5_rdata", {16'd0, rdata}, 32'd0);
        $display("txn s5 aborted read");
        step();
        check_eq("s5_done_later", {30'd0, done}, 32'd0);
        do_access(0, 1'b0, 11'h005, 16'h0000, 16'hBEEF);

        // Scenario 6: max address does not alias address 0.
        do_access(1, 1'b1, 11'h000, 16'h1111, 16'h0000);
        do_access(0, 1'b1, 11'h7FF, 16'hA5C3, 16'h0000);
        do_access(0, 1'b0, 11'h7FF, 16'h0000, 16'hA5C3);
        do_access(1, 1'b0, 11'h000, 16'h0000, 16'h1111);

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
